// File: rtl/ysyx_25040111_ifetch_bridge_pkg.sv
// Shared definitions for the instruction-fetch bridge: FSM encoding, AXI response
// codes, reset PC and small address helpers.
package ysyx_25040111_ifetch_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AR    = 3'd1,
    ST_R     = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  localparam logic [31:0] PC_RESET    = 32'h8000_0000;

  localparam int unsigned WDOG_W      = 8;

  // Instructions are word aligned; any low address bit set is an access fault.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_25040111_ifetch_bridge_timeout_cnt.sv
// Per-fetch watchdog: restarts on clear, counts enabled cycles and flags the cycle
// in which the LIMIT-th enabled cycle is reached.
module ysyx_25040111_timeout_cnt
  import ysyx_25040111_ifetch_bridge_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(LIMIT - 32'd1);

  logic [WDOG_W-1:0] count_r;

  // cycle counter, saturating so a long stall cannot wrap back below LAST
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != {WDOG_W{1'b1}})) begin
      count_r <= count_r + {{(WDOG_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r >= LAST);

endmodule

// File: rtl/ysyx_25040111_ifetch_bridge.sv
// Instruction-fetch bridge: turns fetch-stage requests into single AXI4-Lite reads,
// with alignment check, response check and a per-fetch watchdog.
module ysyx_25040111_ifetch_bridge
  import ysyx_25040111_ifetch_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_valid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_ready,
  output logic [31:0] ifu_inst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        acc_fault,
  output logic [31:0] fault_addr
);

  fetch_state_e state_r, state_s;
  logic [31:0]  req_addr_r, req_addr_s;
  logic [31:0]  inst_r, inst_s;
  logic [31:0]  fault_addr_r, fault_addr_s;
  logic         ar_done_r, ar_done_s;
  logic         arvalid_r, arvalid_s;
  logic         rready_r, rready_s;
  logic         fault_r, fault_s;
  logic         wdog_clear_s, wdog_enable_s, wdog_expired_s;

  assign wdog_clear_s  = (state_r == ST_IDLE);
  assign wdog_enable_s = (state_r == ST_AR) || (state_r == ST_R);

  ysyx_25040111_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wdog_clear_s),
    .enable  (wdog_enable_s),
    .expired (wdog_expired_s)
  );

  // next state, request/data latching and fault generation
  always_comb begin
    state_s      = state_r;
    req_addr_s   = req_addr_r;
    inst_s       = inst_r;
    fault_addr_s = fault_addr_r;
    ar_done_s    = ar_done_r;
    fault_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ifu_valid && is_misaligned(ifu_addr)) begin
          fault_s      = 1'b1;
          fault_addr_s = ifu_addr;
        end else if (ifu_valid) begin
          req_addr_s = ifu_addr;
          ar_done_s  = 1'b0;
          state_s    = ST_AR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_AR: begin
        // an address accepted on the expiry cycle leaves only the R channel to drain
        if (wdog_expired_s) begin
          fault_s      = 1'b1;
          fault_addr_s = req_addr_r;
          ar_done_s    = arready;
          state_s      = ST_DRAIN;
        end else if (arready) begin
          state_s = ST_R;
        end else begin
          state_s = ST_AR;
        end
      end
      ST_R: begin
        if (rvalid && (rresp == RESP_OKAY)) begin
          inst_s  = rdata;
          state_s = ST_RESP;
        end else if (rvalid) begin
          fault_s      = 1'b1;
          fault_addr_s = req_addr_r;
          state_s      = ST_IDLE;
        end else if (wdog_expired_s) begin
          fault_s      = 1'b1;
          fault_addr_s = req_addr_r;
          ar_done_s    = 1'b1;
          state_s      = ST_DRAIN;
        end else begin
          state_s = ST_R;
        end
      end
      ST_RESP: begin
        if (ifu_valid) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_DRAIN: begin
        if (!ar_done_r) begin
          ar_done_s = arready;
        end else if (rvalid) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    arvalid_s = (state_s == ST_AR) || ((state_s == ST_DRAIN) && !ar_done_s);
    rready_s  = (state_s == ST_R)  || ((state_s == ST_DRAIN) && ar_done_s);
  end

  // state and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      req_addr_r   <= 32'd0;
      inst_r       <= 32'd0;
      fault_addr_r <= 32'd0;
      ar_done_r    <= 1'b0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_addr_r   <= req_addr_s;
      inst_r       <= inst_s;
      fault_addr_r <= fault_addr_s;
      ar_done_r    <= ar_done_s;
      arvalid_r    <= arvalid_s;
      rready_r     <= rready_s;
      fault_r      <= fault_s;
    end
  end

  // the consumer must still be asking for this PC when the word is handed over
  assign ifu_ready  = (state_r == ST_RESP) && ifu_valid && (ifu_addr == req_addr_r);
  assign ifu_inst   = inst_r;
  assign araddr     = req_addr_r;
  assign arvalid    = arvalid_r;
  assign rready     = rready_r;
  assign acc_fault  = fault_r;
  assign fault_addr = fault_addr_r;

endmodule

// File: tb/tb_ysyx_25040111_ifetch_bridge.sv
// Bench for the instruction-fetch bridge: latency-configurable AXI slave plus a
// timing model of each fetch derived from channel delays.
module tb_ysyx_25040111_ifetch_bridge;

  localparam int TMO = 4;

  logic        clock, reset;
  logic        ifu_valid, ifu_ready;
  logic [31:0] ifu_addr, ifu_inst;
  logic [31:0] araddr, rdata, fault_addr;
  logic        arvalid, arready, rvalid, rready, acc_fault;
  logic [1:0]  rresp;

  int          total, bad;
  int          cfg_ar_delay = 0, cfg_r_delay = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] cfg_data = 32'd0;
  bit          slave_clear = 1'b0;
  bit          s_pending = 1'b0;
  int          s_ar_cnt = 0, s_r_cnt = 0;
  logic [31:0] model_inst, model_faddr;

  ysyx_25040111_ifetch_bridge #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ifu_valid  (ifu_valid),
    .ifu_addr   (ifu_addr),
    .ifu_ready  (ifu_ready),
    .ifu_inst   (ifu_inst),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .acc_fault  (acc_fault),
    .fault_addr (fault_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // AXI slave: arready after cfg_ar_delay arvalid cycles, rvalid cfg_r_delay cycles after the AR handshake
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
    forever begin
      @(negedge clock);
      if (slave_clear) begin
        s_pending = 1'b0; s_ar_cnt = 0; s_r_cnt = 0;
        arready = 1'b0; rvalid = 1'b0;
      end else begin
        arready = arvalid && !s_pending && (s_ar_cnt >= cfg_ar_delay);
        rvalid  = s_pending && (s_r_cnt >= cfg_r_delay);
        rdata   = rvalid ? cfg_data : 32'hDEAD_BEEF;
        rresp   = rvalid ? cfg_resp : 2'b01;
        #1;
        if (rvalid && rready) s_pending = 1'b0;
        else if (s_pending) s_r_cnt++;
        if (arvalid && arready) begin
          s_pending = 1'b1; s_r_cnt = 0; s_ar_cnt = 0;
        end else if (arvalid) begin
          s_ar_cnt++;
        end
      end
    end
  end

  task automatic tick(input logic v, input logic [31:0] a);
    @(negedge clock);
    ifu_valid = v;
    ifu_addr  = a;
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0; ifu_valid = 1'b0; ifu_addr = 32'd0;
    repeat (3) @(negedge clock);
    #2;
    total++;
    if ({arvalid, rready, ifu_ready, acc_fault} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0000", {arvalid, rready, ifu_ready, acc_fault});
    end
    total++;
    if ({ifu_inst, fault_addr} !== 64'd0) begin
      bad++; $display("FAIL reset_regs inst=%h faddr=%h exp=0", ifu_inst, fault_addr);
    end
    reset = 1'b1;
    tick(1'b0, 32'h8000_0000);
    total++;
    if (arvalid !== 1'b0) begin
      bad++; $display("FAIL idle_no_ar got=%b exp=0", arvalid);
    end
    model_inst = 32'd0; model_faddr = 32'd0;
  endtask

  // directed cases then random fetches; expected event cycles follow from the channel delays
  task automatic test_fetch_mix();
    logic [31:0] addr, data;
    logic [1:0]  resp;
    int          d1, d2, hold, t_fault, t_inst, t_ready, t_end;
    logic        mis, tmo, err, ok, v, exp_arv, exp_rdy, exp_flt;
    for (int n = 0; n < 40; n++) begin
      addr = $urandom() & 32'hFFFF_FFFC;
      data = $urandom();
      resp = 2'b00;
      hold = $urandom_range(0, 3);
      d1   = $urandom_range(0, 5);
      d2   = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) resp = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
      case (n)
        0: begin addr = 32'h8000_0000; data = 32'h0000_0413; resp = 2'b00; d1 = 0; d2 = 0; hold = 0; end
        1: begin addr = 32'h8000_0010; resp = 2'b10; d1 = 0; d2 = 0; end
        2: begin addr = 32'h8000_0002; end
        3: begin addr = 32'h8000_0020; resp = 2'b00; d1 = 7; d2 = 1; end
        4: begin addr = 32'h8000_0030; resp = 2'b00; d1 = 3; d2 = 0; end
        5: begin addr = 32'h8000_0040; resp = 2'b00; d1 = 1; d2 = 1; hold = 2; end
        6: begin addr = 32'h8000_0050; resp = 2'b11; d1 = 0; d2 = 2; end
        default: ;
      endcase
      mis     = (addr[1:0] != 2'b00);
      tmo     = !mis && (d1 + d2 + 2 > TMO);
      err     = !mis && !tmo && (resp != 2'b00);
      ok      = !mis && !tmo && !err;
      t_fault = mis ? 1 : (tmo ? TMO + 1 : (err ? d1 + d2 + 3 : -1));
      t_inst  = ok ? d1 + d2 + 3 : -1;
      t_ready = ok ? d1 + d2 + 3 + hold : -1;
      t_end   = mis ? 2 : ((ok ? t_ready : d1 + d2 + 3) + 1);
      cfg_ar_delay = d1; cfg_r_delay = d2; cfg_resp = resp; cfg_data = data;
      for (int k = 0; k <= t_end; k++) begin
        v = (k == 0) || (k == t_ready);
        tick(v, addr);
        if (k == t_inst)  model_inst  = data;
        if (k == t_fault) model_faddr = addr;
        exp_arv = !mis && (k >= 1) && (k <= d1 + 1);
        exp_rdy = (k == t_ready);
        exp_flt = (k == t_fault);
        total++;
        if (ifu_ready !== exp_rdy) begin
          bad++; $display("FAIL ready n=%0d k=%0d got=%b exp=%b", n, k, ifu_ready, exp_rdy);
        end
        total++;
        if (acc_fault !== exp_flt) begin
          bad++; $display("FAIL fault n=%0d k=%0d got=%b exp=%b", n, k, acc_fault, exp_flt);
        end
        total++;
        if (arvalid !== exp_arv) begin
          bad++; $display("FAIL arvalid n=%0d k=%0d got=%b exp=%b", n, k, arvalid, exp_arv);
        end
        if (exp_arv) begin
          total++;
          if (araddr !== addr) begin
            bad++; $display("FAIL araddr n=%0d k=%0d got=%h exp=%h", n, k, araddr, addr);
          end
        end
        total++;
        if (ifu_inst !== model_inst) begin
          bad++; $display("FAIL inst n=%0d k=%0d got=%h exp=%h", n, k, ifu_inst, model_inst);
        end
        total++;
        if (fault_addr !== model_faddr) begin
          bad++; $display("FAIL faddr n=%0d k=%0d got=%h exp=%h", n, k, fault_addr, model_faddr);
        end
      end
    end
  endtask

  // PC redirect while the old read is in flight: old word dropped, new fetch delivered
  task automatic test_stale();
    logic [31:0] a0, a1, d0, d1v;
    a0 = 32'h8000_0000; a1 = 32'h8000_0100; d0 = 32'h1111_0001; d1v = 32'h2222_0002;
    cfg_ar_delay = 0; cfg_r_delay = 1; cfg_resp = 2'b00; cfg_data = d0;
    for (int k = 0; k <= 11; k++) begin
      if (k == 0) tick(1'b1, a0);
      else if (k == 1) tick(1'b0, a0);
      else if (k <= 8) tick(1'b1, a1);
      else tick(1'b0, a1);
      if (k == 3) begin cfg_r_delay = 0; cfg_data = d1v; end
      total++;
      if (ifu_ready !== (k == 8)) begin
        bad++; $display("FAIL stale_ready k=%0d got=%b exp=%b", k, ifu_ready, (k == 8));
      end
      total++;
      if (acc_fault !== 1'b0) begin
        bad++; $display("FAIL stale_fault k=%0d got=%b exp=0", k, acc_fault);
      end
      if (k == 5) begin
        total++;
        if (ifu_inst !== d0) begin
          bad++; $display("FAIL stale_latched got=%h exp=%h", ifu_inst, d0);
        end
      end
      if (k == 6) begin
        total++;
        if ({arvalid, araddr} !== {1'b1, a1}) begin
          bad++; $display("FAIL stale_refetch got=%b/%h exp=1/%h", arvalid, araddr, a1);
        end
      end
    end
    total++;
    if (ifu_inst !== d1v) begin
      bad++; $display("FAIL stale_inst got=%h exp=%h", ifu_inst, d1v);
    end
  endtask

  // asynchronous reset in R, late rvalid afterwards, then first-edge acceptance
  task automatic test_reset_mid();
    logic [31:0] a;
    a = 32'h8000_0200;
    cfg_ar_delay = 0; cfg_r_delay = 6; cfg_resp = 2'b00; cfg_data = 32'h3333_0003;
    tick(1'b1, a);
    tick(1'b0, a);
    tick(1'b0, a);
    total++;
    if (rready !== 1'b1) begin
      bad++; $display("FAIL rst_pre_rready got=%b exp=1", rready);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if ({arvalid, rready, ifu_ready, acc_fault} !== 4'b0000) begin
      bad++; $display("FAIL rst_async_strobes got=%b exp=0000", {arvalid, rready, ifu_ready, acc_fault});
    end
    total++;
    if ({ifu_inst, fault_addr} !== 64'd0) begin
      bad++; $display("FAIL rst_async_regs inst=%h faddr=%h exp=0", ifu_inst, fault_addr);
    end
    tick(1'b0, a);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, a);
      total++;
      if ({arvalid, rready, ifu_ready, acc_fault} !== 4'b0000) begin
        bad++; $display("FAIL rst_late k=%0d got=%b exp=0000", k, {arvalid, rready, ifu_ready, acc_fault});
      end
    end
    total++;
    if (rvalid !== 1'b1) begin
      bad++; $display("FAIL rst_late_rvalid got=%b exp=1", rvalid);
    end
    slave_clear = 1'b1;
    tick(1'b0, a);
    slave_clear = 1'b0;
    a = 32'h8000_0300;
    cfg_r_delay = 0; cfg_data = 32'h4444_0004;
    @(negedge clock);
    reset = 1'b0; ifu_valid = 1'b1; ifu_addr = a;
    @(negedge clock);
    reset = 1'b1;
    tick(1'b0, a);
    total++;
    if ({arvalid, araddr} !== {1'b1, a}) begin
      bad++; $display("FAIL rst_first_edge got=%b/%h exp=1/%h", arvalid, araddr, a);
    end
    tick(1'b0, a);
    tick(1'b1, a);
    total++;
    if ({ifu_ready, ifu_inst} !== {1'b1, 32'h4444_0004}) begin
      bad++; $display("FAIL rst_refetch got=%b/%h exp=1/44440004", ifu_ready, ifu_inst);
    end
    tick(1'b0, a);
    total++;
    if (ifu_ready !== 1'b0) begin
      bad++; $display("FAIL rst_refetch_once got=%b exp=0", ifu_ready);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_fetch_mix();
    test_stale();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
